// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS boot path.
// The CSUM state only exists when IMEM_LOADER_CSUM_EN is defined.
package mips_pkg;

   localparam int IMEM_WORD_BYTES = 4;
   localparam int IMEM_LEN_BYTES  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM   = 3'd5,
`endif
      ST_DONE   = 3'd6,
      ST_ERR    = 3'd7
   } imem_ld_state_t;

   // Running frame checksum: XOR of every count and data byte.
   function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: shifts stream bytes (MSB first) into a 32-bit word and flags
// the byte that completes it. word_full is asserted together with the
// accepted 4th byte, so the loader can move to its write cycle on that edge.
module word_packer
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   localparam logic [1:0] LAST_IDX = 2'(IMEM_WORD_BYTES - 1);

   logic [31:0] data_q, data_d;
   logic [1:0]  idx_q, idx_d;

   // Next shift-register contents and byte index.
   always_comb begin
      data_d = data_q;
      idx_d  = idx_q;
      if (clr) begin
         idx_d = 2'd0;
      end else if (shift_en) begin
         data_d = {data_q[23:0], byte_in};
         idx_d  = idx_q + 2'd1;
      end else begin
         idx_d = idx_q;
      end
   end

   // Shift register and index flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= 32'h0000_0000;
         idx_q  <= 2'd0;
      end else begin
         data_q <= data_d;
         idx_q  <= idx_d;
      end
   end

   assign word      = data_q;
   assign word_full = shift_en && !clr && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer. Takes a framed byte
// stream (16-bit word count, N big-endian words, optional checksum byte),
// writes each word to consecutive word addresses from BASE_ADDR, and holds
// the core in reset for the duration of the load.
// Optional feature macro: IMEM_LOADER_CSUM_EN (trailing XOR checksum byte).
module imem_loader
   import mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256
) (
   input  logic        CLOCK_50,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        core_hold,
   output logic        done,
   output logic        error
);

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

   imem_ld_state_t state_q, state_d;
   logic [15:0]    len_q, len_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [31:0]    addr_q, addr_d;
   logic [15:0]    n_s;
   logic [15:0]    cnt_inc_s;
   logic           accept_s;
   logic           clr_s;
   logic           shift_s;
   logic           word_full_s;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]     csum_q, csum_d;
`endif

   assign accept_s  = byte_valid && byte_ready;
   assign n_s       = {len_q[15:8], byte_data};
   assign cnt_inc_s = cnt_q + 16'd1;
   assign clr_s     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
   assign shift_s   = accept_s && (state_q == ST_DATA);

   word_packer u_packer (
      .clk       (CLOCK_50),
      .rst_n     (rst),
      .clr       (clr_s),
      .shift_en  (shift_s),
      .byte_in   (byte_data),
      .word      (wr_data),
      .word_full (word_full_s)
   );

   // State register.
   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LEN_HI;
            else       state_d = ST_IDLE;
         end
         ST_LEN_HI: begin
            if (accept_s) state_d = ST_LEN_LO;
            else          state_d = ST_LEN_HI;
         end
         ST_LEN_LO: begin
            if (!accept_s) begin
               state_d = ST_LEN_LO;
            end else if ({16'h0000, n_s} > MAX_W) begin
               state_d = ST_ERR;
            end else if (n_s == 16'h0000) begin
`ifdef IMEM_LOADER_CSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_DONE;
`endif
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (word_full_s) state_d = ST_WRITE;
            else             state_d = ST_DATA;
         end
         ST_WRITE: begin
            if (cnt_inc_s == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_DONE;
`endif
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         ST_CSUM: begin
            if (!accept_s)                state_d = ST_CSUM;
            else if (byte_data == csum_q) state_d = ST_DONE;
            else                          state_d = ST_ERR;
         end
`endif
         ST_DONE, ST_ERR: begin
            if (start) state_d = ST_LEN_HI;
            else       state_d = state_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      byte_ready = 1'b0;
      wr_en      = 1'b0;
      core_hold  = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state_q)
         ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
            byte_ready = 1'b1;
            core_hold  = 1'b1;
         end
`ifdef IMEM_LOADER_CSUM_EN
         ST_CSUM: begin
            byte_ready = 1'b1;
            core_hold  = 1'b1;
         end
`endif
         ST_WRITE: begin
            wr_en     = 1'b1;
            core_hold = 1'b1;
         end
         ST_DONE: done  = 1'b1;
         ST_ERR:  error = 1'b1;
         default: core_hold = 1'b0;
      endcase
   end

   // Count capture, word counter and write address.
   always_comb begin
      len_d  = len_q;
      cnt_d  = cnt_q;
      addr_d = addr_q;
      if (clr_s) begin
         len_d  = 16'h0000;
         cnt_d  = 16'h0000;
         addr_d = BASE_ADDR;
      end else begin
         case (state_q)
            ST_LEN_HI: begin
               if (accept_s) len_d = {byte_data, 8'h00};
               else          len_d = len_q;
            end
            ST_LEN_LO: begin
               if (accept_s) len_d = n_s;
               else          len_d = len_q;
            end
            ST_WRITE: begin
               cnt_d  = cnt_inc_s;
               addr_d = addr_q + 32'd4;
            end
            default: len_d = len_q;
         endcase
      end
   end

`ifdef IMEM_LOADER_CSUM_EN
   // Running checksum over count and data bytes.
   always_comb begin
      csum_d = csum_q;
      if (clr_s) begin
         csum_d = 8'h00;
      end else if (accept_s && ((state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                                (state_q == ST_DATA))) begin
         csum_d = csum_next(csum_q, byte_data);
      end else begin
         csum_d = csum_q;
      end
   end

   // Checksum register.
   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) begin
         csum_q <= 8'h00;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

   // Datapath registers.
   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) begin
         len_q  <= 16'h0000;
         cnt_q  <= 16'h0000;
         addr_q <= BASE_ADDR;
      end else begin
         len_q  <= len_d;
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
      end
   end

   assign wr_addr = addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frame vectors plus hand-written sequences for
// reset mid-word and start-while-busy. Works with and without
// IMEM_LOADER_CSUM_EN. A second instance with BASE_ADDR near the top of the
// address space shares the stimulus to cover address wrap.
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, wr_en, core_hold, done, error;
   logic [31:0] wr_addr, wr_data;
   logic        byte_ready1, wr_en1, core_hold1, done1, error1;
   logic [31:0] wr_addr1, wr_data1;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

   imem_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(256)) dut (
      .CLOCK_50(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .core_hold(core_hold),
      .done(done), .error(error)
   );

   imem_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(256)) dut_wrap (
      .CLOCK_50(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready1), .wr_en(wr_en1),
      .wr_addr(wr_addr1), .wr_data(wr_data1), .core_hold(core_hold1),
      .done(done1), .error(error1)
   );

   typedef struct {
      logic [15:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        bad_csum;
      int          gap_max;
   } vec_t;

   typedef struct {
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] d;
   } wr_t;

   int   checks   = 0;
   int   failures = 0;
   wr_t  wq[$];
   vec_t vecs[7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Capture every write strobe and confirm no byte can be taken during it.
   always @(negedge clk) begin
      if (wr_en) begin
         wq.push_back('{wr_addr, wr_addr1, wr_data});
         checks++;
         if (byte_ready) begin
            failures++;
            $display("FAIL ready_in_write actual=1 required=0");
         end
      end
   end

   // Present one byte after a gap; returns at the negedge after it is taken.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         checks++;
         failures++;
         $display("FAIL byte_timeout actual=not_ready required=ready");
      end else begin
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [31:0] word_k(input vec_t v, input int k);
      return (k == 0) ? v.w0 : v.w1 + 32'(k - 1);
   endfunction

   task automatic run_frame(input vec_t v, input string tag);
      logic [7:0]  cs;
      logic [31:0] w;
      logic        over;
      logic        exp_err;
      int          exp_lat;
      int          lat;
      int          nexp;
      over = (32'(v.n) > 32'd256);
      nexp = over ? 0 : int'(v.n);
      wq.delete();
      pulse_start();
      chk({tag, ".hold"},  32'(core_hold),  32'd1);
      chk({tag, ".ready"}, 32'(byte_ready), 32'd1);
      chk({tag, ".clr"},   {30'd0, done, error}, 32'd0);
      cs = v.n[15:8] ^ v.n[7:0];
      send_byte(v.n[15:8], $urandom_range(0, v.gap_max));
      send_byte(v.n[7:0],  $urandom_range(0, v.gap_max));
      for (int k = 0; k < nexp; k++) begin
         w = word_k(v, k);
         for (int b = 3; b >= 0; b--) begin
            cs = cs ^ w[8*b +: 8];
            send_byte(w[8*b +: 8], $urandom_range(0, v.gap_max));
         end
      end
`ifdef IMEM_LOADER_CSUM_EN
      if (!over) send_byte(v.bad_csum ? 8'h00 : cs, $urandom_range(0, v.gap_max));
      exp_err = over || v.bad_csum;
      exp_lat = 0;
`else
      exp_err = over;
      exp_lat = (over || v.n == 16'd0) ? 0 : 1;
`endif
      lat = 0;
      while (!(done || error) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".done"},  32'(done),  32'(!exp_err));
      chk({tag, ".error"}, 32'(error), 32'(exp_err));
      chk({tag, ".hold_off"}, 32'(core_hold), 32'd0);
      chk({tag, ".nwrites"}, 32'(wq.size()), 32'(nexp));
      for (int i = 0; i < nexp && i < wq.size(); i++) begin
         chk($sformatf("%s.data%0d", tag, i),  wq[i].d,  word_k(v, i));
         chk($sformatf("%s.addr%0d", tag, i),  wq[i].a0, BASE0 + 32'(4 * i));
         chk($sformatf("%s.waddr%0d", tag, i), wq[i].a1, BASE1 + 32'(4 * i));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".ready"}, 32'(byte_ready), 32'd0);
      chk({tag, ".wr_en"}, 32'(wr_en),      32'd0);
      chk({tag, ".hold"},  32'(core_hold),  32'd0);
      chk({tag, ".done"},  32'(done),       32'd0);
      chk({tag, ".error"}, 32'(error),      32'd0);
      chk({tag, ".addr"},  wr_addr,         BASE0);
      chk({tag, ".waddr"}, wr_addr1,        BASE1);
      chk({tag, ".data"},  wr_data,         32'h0000_0000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cs;
      // n, w0, w1, bad checksum, max gap between bytes
      vecs[0] = '{16'd2,   32'h2008_0005, 32'h0000_0008, 1'b0, 0};
      vecs[1] = '{16'd2,   32'h2008_0005, 32'h0000_0008, 1'b1, 0};
      vecs[2] = '{16'd257, 32'h0000_0000, 32'h0000_0000, 1'b0, 0};
      vecs[3] = '{16'd2,   32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 3};
      vecs[4] = '{16'd0,   32'h0000_0000, 32'h0000_0000, 1'b0, 0};
      vecs[5] = '{16'd256, 32'h0000_1000, 32'h0000_2000, 1'b0, 0};
      vecs[6] = '{16'd1,   32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2};

      rst        = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("idle");

      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i], $sformatf("v%0d", i));
      end

      // Reset after two data bytes of a word, then a fresh frame.
      wq.delete();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      rst = 1'b0;
      #1;
      chk_reset_vals("midrst");
      chk("midrst.nwrites", 32'(wq.size()), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_frame(vecs[0], "after_rst");

      // A start pulse in the middle of a word must be ignored.
      wq.delete();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAB, 0);
      pulse_start();
      chk("busy.hold", 32'(core_hold), 32'd1);
      send_byte(8'hCD, 0);
      send_byte(8'hEF, 0);
      send_byte(8'h01, 0);
`ifdef IMEM_LOADER_CSUM_EN
      cs = 8'h00 ^ 8'h01 ^ 8'hAB ^ 8'hCD ^ 8'hEF ^ 8'h01;
      send_byte(cs, 0);
`else
      cs = 8'h00;
      @(negedge clk);
`endif
      chk("busy.done",    32'(done),      32'd1);
      chk("busy.error",   32'(error),     32'd0);
      chk("busy.nwrites", 32'(wq.size()), 32'd1);
      if (wq.size() > 0) begin
         chk("busy.data", wq[0].d,  32'hABCD_EF01);
         chk("busy.addr", wq[0].a0, BASE0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
